tone_gen: RTL and testbench
===========================

TONE_GEN -- requirements
Module: tone_gen

Interface
REQ-001 SHALL have parameters: DIV=1024 (clk cycles per sample tick); ATTACK_STEP=4; DECAY_STEP=1; SUSTAIN_LVL=160; RELEASE_STEP=1 (env units per tick).
REQ-002 SHALL use one clock and an asynchronous, active-low reset: clk_50Mhz  input  1  system clock; reset_n  input  1  asynchronous, active-low reset.
REQ-003 SHALL have key_on  input  1  debounced key level.
REQ-004 SHALL have note  input  4  note index: 0..11 = C4..B4, 12..15 = rest.
REQ-005 SHALL have wave_sel  input  1  waveform select: 0 = square, 1 = sawtooth.
REQ-006 SHALL have sample_out  output  14  unsigned sample for the downstream pwm data_in.
REQ-007 SHALL have env_state  output  3  envelope state code.
REQ-008 SHALL have busy  output  1  high when env_state != IDLE.

Function
REQ-009 SHALL use a prescaler counting 0..DIV-1 and raise an internal one-cycle tick when count==DIV-1, giving 48828.125 Hz at DIV=1024; all state below changes only on tick cycles.
REQ-010 SHALL hold a 24-bit phase accumulator; each tick: phase <= (phase + inc[note_l]) mod 2^24, with note_l the latched note.
REQ-011 SHALL define inc[n] = round(440*2^((n-9)/12) * 2^24 / 48828.125) for n=0..11 (inc[9]=151183), and inc=0 for n=12..15.
REQ-012 SHALL produce the 13-bit raw waveform w as follows: square = phase[23] ? 8191 : 0; sawtooth = phase[23:11].
REQ-013 SHALL hold an 8-bit envelope env (0..255).
REQ-014 SHALL register sample_out <= (w*env)>>7 on each tick from pre-tick phase/env (one-tick latency); 21-bit product, max 16318, never overflows.
REQ-015 SHALL implement FSM states IDLE=0, ATTACK=1, DECAY=2, SUSTAIN=3, RELEASE=4, with env_state equal to the code.
REQ-016 IDLE: on a tick with key_on=1 -> ATTACK; latch note_l; phase<=0; env stays 0.
REQ-017 ATTACK: each tick env<=min(env+ATTACK_STEP,255); on reaching 255 -> DECAY.
REQ-018 DECAY: each tick env<=max(env-DECAY_STEP,SUSTAIN_LVL); on reaching SUSTAIN_LVL -> SUSTAIN.
REQ-019 SUSTAIN: SHALL hold env.
REQ-020 A tick with key_on=0 in ATTACK/DECAY/SUSTAIN SHALL -> RELEASE, with no env change on that tick.
REQ-021 RELEASE: each tick env<=max(env-RELEASE_STEP,0); at 0 -> IDLE.
REQ-022 A tick with key_on=1 in RELEASE SHALL -> ATTACK from the current env, relatching note_l, with phase NOT reset.
REQ-023 Note changes while not entering ATTACK SHALL be ignored.
REQ-024 key_on level between ticks SHALL be ignored, as only the level sampled at the tick matters.
REQ-025 A rest note SHALL freeze phase while the envelope proceeds normally.

Reset
REQ-026 reset_n low SHALL asynchronously clear prescaler, phase, env, note_l and sample_out to 0, and set state to IDLE and busy to 0.
REQ-027 Assertion of reset_n mid-note SHALL abort the note immediately, with no release.
REQ-028 After reset_n deasserts, the first tick SHALL occur DIV cycles later.

Structure
REQ-029 Shared package tone_pkg SHALL hold the state encodings, the 12-entry inc table, and the parameter defaults.
REQ-030 SHALL contain one sub-module, tone_rom (combinational note -> 24-bit inc); everything else stays in tone_gen.

Verification
REQ-031 Reset, key_on=1, note=9, square: ATTACK entered at tick 1; env=255 and DECAY reached 64 ticks later; SUSTAIN at env=160 after 95 further ticks; busy=1 throughout.
REQ-032 Phase check: after N ticks in ATTACK/SUSTAIN, phase == N*151183 mod 2^24; square period 110-111 ticks; sample_out high value in SUSTAIN = 10238.
REQ-033 key_on=0 in SUSTAIN -> RELEASE; env reaches 0 after 160 ticks -> IDLE, busy=0, sample_out=0 on the following tick.
REQ-034 Retrigger: key_on=1 in RELEASE at env=80 with note changed to 0 -> ATTACK from env 80, phase continuous, inc switches to inc[0].
REQ-035 Sawtooth, env=255, phase[23:11]=8191 -> sample_out=16318; note=13 -> phase constant over 500 ticks.
REQ-036 reset_n pulsed low mid-DECAY, asynchronously between clock edges -> all outputs 0 and env_state=IDLE before the next edge.

Source files
------------

// File: rtl/tone_pkg.sv
// ---------------------------------------------------------------------------
// tone_pkg
// Shared definitions for the tone generator: envelope state encodings,
// datapath widths, parameter defaults and the 12-entry phase-increment table
// for notes C4..B4 at a 48828.125 Hz sample rate.
// ---------------------------------------------------------------------------
package tone_pkg;

    // Envelope state codes; these values appear on env_state directly.
    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_ATTACK  = 3'd1,
        ST_DECAY   = 3'd2,
        ST_SUSTAIN = 3'd3,
        ST_RELEASE = 3'd4
    } env_state_e;

    localparam int unsigned PHASE_W  = 24;
    localparam int unsigned WAVE_W   = 13;
    localparam int unsigned ENV_W    = 8;
    localparam int unsigned SAMPLE_W = 14;
    localparam int unsigned NOTE_W   = 4;

    localparam int unsigned DIV_DEF          = 1024;
    localparam int unsigned ATTACK_STEP_DEF  = 4;
    localparam int unsigned DECAY_STEP_DEF   = 1;
    localparam int unsigned SUSTAIN_LVL_DEF  = 160;
    localparam int unsigned RELEASE_STEP_DEF = 1;

    localparam int unsigned NUM_NOTES = 12;

    // round(f_note * 2^24 / 48828.125), equal-tempered around A4 = 440 Hz.
    localparam logic [PHASE_W-1:0] INC_TABLE [0:NUM_NOTES-1] = '{
        24'd89894,   // C4
        24'd95239,   // C#4
        24'd100902,  // D4
        24'd106902,  // D#4
        24'd113259,  // E4
        24'd119994,  // F4
        24'd127129,  // F#4
        24'd134689,  // G4
        24'd142698,  // G#4
        24'd151183,  // A4
        24'd160173,  // A#4
        24'd169697   // B4
    };

endpackage

// File: rtl/tone_rom.sv
// ---------------------------------------------------------------------------
// tone_rom
// Combinational lookup from note index to 24-bit phase increment.
// Indices 12..15 are rests and return zero so the phase stays frozen.
//   note_i : 4-bit note index
//   inc_o  : phase increment per sample tick
// ---------------------------------------------------------------------------
module tone_rom
    import tone_pkg::*;
(
    input  logic [NOTE_W-1:0]  note_i,
    output logic [PHASE_W-1:0] inc_o
);

    always_comb begin
        inc_o = '0;
        if (note_i < 4'd12) begin
            inc_o = INC_TABLE[note_i];
        end
    end

endmodule

// File: rtl/tone_gen.sv
// ---------------------------------------------------------------------------
// tone_gen
// Single-voice tone generator: prescaled sample tick, 24-bit phase
// accumulator, square/sawtooth waveform and an ADSR-style 8-bit envelope.
// The output sample is (wave * env) >> 7, registered once per tick.
//   clk_50Mhz  : system clock
//   reset_n    : asynchronous active-low reset
//   key_on     : debounced key level, sampled only on tick cycles
//   note       : note index (0..11 = C4..B4, 12..15 = rest)
//   wave_sel   : 0 = square, 1 = sawtooth
//   sample_out : 14-bit unsigned sample for the downstream PWM
//   env_state  : envelope state code
//   busy       : high whenever the envelope is not idle
// ---------------------------------------------------------------------------
module tone_gen
    import tone_pkg::*;
#(
    parameter int unsigned DIV          = DIV_DEF,
    parameter int unsigned ATTACK_STEP  = ATTACK_STEP_DEF,
    parameter int unsigned DECAY_STEP   = DECAY_STEP_DEF,
    parameter int unsigned SUSTAIN_LVL  = SUSTAIN_LVL_DEF,
    parameter int unsigned RELEASE_STEP = RELEASE_STEP_DEF
) (
    input  logic                clk_50Mhz,
    input  logic                reset_n,
    input  logic                key_on,
    input  logic [NOTE_W-1:0]   note,
    input  logic                wave_sel,
    output logic [SAMPLE_W-1:0] sample_out,
    output logic [2:0]          env_state,
    output logic                busy
);

    localparam int unsigned CNT_W = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIV - 1);

    // Envelope arithmetic is done one bit wider so attack overshoot past
    // 255 can be detected before clamping.
    localparam logic [ENV_W:0] ENV_MAX     = 9'd255;
    localparam logic [ENV_W:0] ATK_STEP9   = 9'(ATTACK_STEP);
    localparam logic [ENV_W:0] DEC_FLOOR9  = 9'(SUSTAIN_LVL + DECAY_STEP);
    localparam logic [ENV_W:0] REL_STEP9   = 9'(RELEASE_STEP);
    localparam logic [ENV_W-1:0] SUS_LVL8  = 8'(SUSTAIN_LVL);
    localparam logic [ENV_W-1:0] DEC_STEP8 = 8'(DECAY_STEP);
    localparam logic [ENV_W-1:0] REL_STEP8 = 8'(RELEASE_STEP);

    logic [CNT_W-1:0]    cnt_q,    cnt_d;
    env_state_e          state_q,  state_d;
    logic [PHASE_W-1:0]  phase_q,  phase_d;
    logic [ENV_W-1:0]    env_q,    env_d;
    logic [NOTE_W-1:0]   note_l_q, note_l_d;
    logic [SAMPLE_W-1:0] sample_q, sample_d;

    logic                tick;
    logic [PHASE_W-1:0]  inc;
    logic [WAVE_W-1:0]   wave;
    logic [20:0]         product;
    logic [ENV_W:0]      env_atk;

    // Increment follows the latched note, so note changes mid-note are
    // ignored until the next entry into attack.
    tone_rom u_rom (
        .note_i (note_l_q),
        .inc_o  (inc)
    );

    assign tick    = (cnt_q == CNT_LAST);
    assign wave    = wave_sel ? phase_q[PHASE_W-1 -: WAVE_W]
                              : (phase_q[PHASE_W-1] ? {WAVE_W{1'b1}} : '0);
    assign product = 21'(wave) * 21'(env_q);
    assign env_atk = {1'b0, env_q} + ATK_STEP9;

    // Next-state logic: nothing but the prescaler moves between ticks.
    // The sample uses the pre-tick phase and envelope, giving one tick of
    // latency. Entering attack from idle restarts the phase; a retrigger
    // from release keeps it running for a click-free restart.
    always_comb begin
        cnt_d    = tick ? '0 : cnt_q + 1'b1;
        state_d  = state_q;
        phase_d  = phase_q;
        env_d    = env_q;
        note_l_d = note_l_q;
        sample_d = sample_q;
        if (tick) begin
            sample_d = 14'(product >> 7);
            phase_d  = phase_q + inc;
            unique case (state_q)
                ST_IDLE: begin
                    if (key_on) begin
                        state_d  = ST_ATTACK;
                        note_l_d = note;
                        phase_d  = '0;
                    end
                end
                ST_ATTACK: begin
                    if (!key_on) begin
                        state_d = ST_RELEASE;
                    end else if (env_atk >= ENV_MAX) begin
                        env_d   = 8'd255;
                        state_d = ST_DECAY;
                    end else begin
                        env_d = env_atk[ENV_W-1:0];
                    end
                end
                ST_DECAY: begin
                    if (!key_on) begin
                        state_d = ST_RELEASE;
                    end else if ({1'b0, env_q} <= DEC_FLOOR9) begin
                        env_d   = SUS_LVL8;
                        state_d = ST_SUSTAIN;
                    end else begin
                        env_d = env_q - DEC_STEP8;
                    end
                end
                ST_SUSTAIN: begin
                    if (!key_on) begin
                        state_d = ST_RELEASE;
                    end
                end
                ST_RELEASE: begin
                    if (key_on) begin
                        state_d  = ST_ATTACK;
                        note_l_d = note;
                    end else if ({1'b0, env_q} <= REL_STEP9) begin
                        env_d   = '0;
                        state_d = ST_IDLE;
                    end else begin
                        env_d = env_q - REL_STEP8;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                    env_d   = '0;
                end
            endcase
        end
    end

    // Reset aborts any note immediately; nothing fades out.
    always_ff @(posedge clk_50Mhz or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q    <= '0;
            state_q  <= ST_IDLE;
            phase_q  <= '0;
            env_q    <= '0;
            note_l_q <= '0;
            sample_q <= '0;
        end else begin
            cnt_q    <= cnt_d;
            state_q  <= state_d;
            phase_q  <= phase_d;
            env_q    <= env_d;
            note_l_q <= note_l_d;
            sample_q <= sample_d;
        end
    end

    assign sample_out = sample_q;
    assign env_state  = state_q;
    assign busy       = (state_q != ST_IDLE);

endmodule

// File: tb/tb_tone_gen.sv
// ---------------------------------------------------------------------------
// tb_tone_gen
// Directed bench for tone_gen, run with a short prescaler so a full
// attack/decay/sustain/release cycle fits in a few thousand clocks.
// ---------------------------------------------------------------------------
module tb_tone_gen;

    localparam int unsigned DIV_T   = 4;
    localparam int unsigned INC_A4  = 151183;
    localparam int unsigned INC_C4  = 89894;

    logic        clk_50Mhz;
    logic        reset_n;
    logic        key_on;
    logic [3:0]  note;
    logic        wave_sel;
    logic [13:0] sample_out;
    logic [2:0]  env_state;
    logic        busy;

    int errors = 0;
    int checks = 0;

    tone_gen #(
        .DIV (DIV_T)
    ) dut (
        .clk_50Mhz  (clk_50Mhz),
        .reset_n    (reset_n),
        .key_on     (key_on),
        .note       (note),
        .wave_sel   (wave_sel),
        .sample_out (sample_out),
        .env_state  (env_state),
        .busy       (busy)
    );

    initial begin
        clk_50Mhz = 1'b0;
        forever #5 clk_50Mhz = ~clk_50Mhz;
    end

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("[TB] FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Advance n sample ticks and settle just after the last tick edge.
    task automatic applyStimulus(input int n);
        repeat (n * DIV_T) @(posedge clk_50Mhz);
        #1;
    endtask

    initial begin
        logic [23:0] pm;
        logic [23:0] pf;
        int          envM;
        int          expS;
        int          lastRise;
        int          period;
        logic [13:0] prevS;

        reset_n  = 1'b0;
        key_on   = 1'b1;
        note     = 4'd9;
        wave_sel = 1'b0;

        #12;
        checkOutput("reset_sample", sample_out, 0);
        checkOutput("reset_state", env_state, 0);
        checkOutput("reset_busy", busy, 0);

        @(posedge clk_50Mhz);
        #1;
        reset_n = 1'b1;

        // Attack from A4, square wave.
        applyStimulus(1);
        checkOutput("attack_entry_state", env_state, 1);
        checkOutput("attack_entry_busy", busy, 1);
        checkOutput("attack_entry_env", dut.env_q, 0);
        checkOutput("attack_entry_phase", dut.phase_q, 0);

        applyStimulus(63);
        checkOutput("attack63_state", env_state, 1);
        checkOutput("attack63_env", dut.env_q, 252);
        checkOutput("attack63_phase", dut.phase_q, 9524529);

        applyStimulus(1);
        checkOutput("decay_entry_state", env_state, 2);
        checkOutput("decay_entry_env", dut.env_q, 255);
        checkOutput("decay_entry_busy", busy, 1);

        applyStimulus(94);
        checkOutput("decay94_state", env_state, 2);
        checkOutput("decay94_env", dut.env_q, 161);

        applyStimulus(1);
        checkOutput("sustain_state", env_state, 3);
        checkOutput("sustain_env", dut.env_q, 160);
        checkOutput("sustain_phase", dut.phase_q, 7260881);
        checkOutput("sustain_busy", busy, 1);

        // Square wave in sustain: track samples and measure the period.
        pm       = 24'd7260881;
        lastRise = -1;
        period   = 0;
        prevS    = sample_out;
        for (int i = 0; i < 250; i++) begin
            expS = pm[23] ? 10238 : 0;
            pm   = pm + 24'(INC_A4);
            applyStimulus(1);
            checkOutput("sustain_sample", sample_out, expS);
            if (sample_out == 14'd10238 && prevS == 14'd0) begin
                if (lastRise >= 0) period = i - lastRise;
                lastRise = i;
            end
            prevS = sample_out;
        end
        checkOutput("square_period_ok", (period == 110 || period == 111), 1);
        checkOutput("sustain_phase_track", dut.phase_q, pm);

        // Release all the way to idle.
        key_on = 1'b0;
        applyStimulus(1);
        checkOutput("release_entry_state", env_state, 4);
        checkOutput("release_entry_env", dut.env_q, 160);
        applyStimulus(159);
        checkOutput("release159_state", env_state, 4);
        checkOutput("release159_env", dut.env_q, 1);
        applyStimulus(1);
        checkOutput("idle_state", env_state, 0);
        checkOutput("idle_busy", busy, 0);
        checkOutput("idle_env", dut.env_q, 0);
        applyStimulus(1);
        checkOutput("idle_sample", sample_out, 0);
        checkOutput("idle_hold_state", env_state, 0);

        // New note; a note change after entry must be ignored.
        key_on = 1'b1;
        note   = 4'd9;
        applyStimulus(1);
        checkOutput("reentry_state", env_state, 1);
        checkOutput("reentry_phase", dut.phase_q, 0);
        note = 4'd5;
        applyStimulus(20);
        checkOutput("attack20_env", dut.env_q, 80);
        checkOutput("attack20_phase", dut.phase_q, 3023660);

        // Release at env 80, then retrigger on C4.
        key_on = 1'b0;
        applyStimulus(1);
        checkOutput("rel80_state", env_state, 4);
        checkOutput("rel80_env", dut.env_q, 80);
        checkOutput("rel80_phase", dut.phase_q, 3174843);
        key_on = 1'b1;
        note   = 4'd0;
        applyStimulus(1);
        checkOutput("retrig_state", env_state, 1);
        checkOutput("retrig_env", dut.env_q, 80);
        checkOutput("retrig_phase", dut.phase_q, 3326026);
        applyStimulus(1);
        checkOutput("retrig_next_env", dut.env_q, 84);
        checkOutput("retrig_next_phase", dut.phase_q, 3415920);

        // Sawtooth during attack.
        wave_sel = 1'b1;
        pm       = 24'd3415920;
        envM     = 84;
        for (int i = 0; i < 10; i++) begin
            expS = (int'(pm[23:11]) * envM) >> 7;
            pm   = pm + 24'(INC_C4);
            envM = (envM + 4 > 255) ? 255 : envM + 4;
            applyStimulus(1);
            checkOutput("saw_sample", sample_out, expS);
            checkOutput("saw_env", dut.env_q, envM);
        end

        // Retrigger onto a rest: phase freezes, envelope continues.
        key_on = 1'b0;
        applyStimulus(1);
        key_on = 1'b1;
        note   = 4'd13;
        applyStimulus(1);
        pf = pm + 24'(2 * INC_C4);
        checkOutput("rest_entry_state", env_state, 1);
        checkOutput("rest_entry_phase", dut.phase_q, pf);
        applyStimulus(500);
        checkOutput("rest_phase_frozen", dut.phase_q, pf);
        checkOutput("rest_state", env_state, 3);
        checkOutput("rest_env", dut.env_q, 160);

        // Reach decay again, then reset asynchronously between edges.
        key_on = 1'b0;
        applyStimulus(1);
        key_on = 1'b1;
        applyStimulus(1);
        checkOutput("rearm_env", dut.env_q, 160);
        applyStimulus(24);
        checkOutput("rearm_decay_state", env_state, 2);
        checkOutput("rearm_decay_env", dut.env_q, 255);
        applyStimulus(3);
        checkOutput("mid_decay_env", dut.env_q, 252);

        @(posedge clk_50Mhz);
        #3;
        reset_n = 1'b0;
        #1;
        checkOutput("async_rst_sample", sample_out, 0);
        checkOutput("async_rst_state", env_state, 0);
        checkOutput("async_rst_busy", busy, 0);
        checkOutput("async_rst_env", dut.env_q, 0);
        checkOutput("async_rst_phase", dut.phase_q, 0);

        // First tick after reset release lands exactly DIV clocks later.
        #3;
        key_on   = 1'b1;
        note     = 4'd9;
        wave_sel = 1'b0;
        @(posedge clk_50Mhz);
        #1;
        reset_n = 1'b1;
        repeat (DIV_T - 1) @(posedge clk_50Mhz);
        #1;
        checkOutput("pre_first_tick_state", env_state, 0);
        @(posedge clk_50Mhz);
        #1;
        checkOutput("first_tick_state", env_state, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
